cs4344_i2s_tx: RTL and testbench



---
 rtl/cs4344_pkg.sv | 17 +
 rtl/cs4344_clk_div.sv | 64 ++++++
 rtl/cs4344_i2s_tx.sv | 113 +++++++++++
 tb/tb_cs4344_i2s_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cs4344_pkg.sv
// Shared constants and helpers for the CS4344 I2S transmitter.
package cs4344_pkg;

  // Default geometry: 16-bit samples in 32-bit slots, 24.576 MHz system clock
  localparam int DATA_W     = 16;
  localparam int SLOT_W     = 32;
  localparam int SCLK_DIV   = 8;
  localparam int MCLK_DIV   = 2;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int FRAME_CLKS = FRAME_BITS * SCLK_DIV;

  // A divided clock is high during the second half of its period
  function automatic logic phase_high(input int phase, input int period);
    return phase >= (period / 2);
  endfunction

endpackage

// File: rtl/cs4344_clk_div.sv
// Clock and frame timing generator: SCLK phase counter, bit counter and the
// derived MCLK / SCLK / LRCK pins plus strobes for the serializer.
module cs4344_clk_div
#(
  parameter int SLOT_W   = cs4344_pkg::SLOT_W,
  parameter int SCLK_DIV = cs4344_pkg::SCLK_DIV,
  parameter int MCLK_DIV = cs4344_pkg::MCLK_DIV
) (
  input  logic clk,
  input  logic srst,
  output logic mclk,
  output logic sclk,
  output logic lrck,
  output logic fall_stb,
  output logic frame_stb
);
  import cs4344_pkg::*;

  localparam int SC_W  = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);

  logic [SC_W-1:0]  sc_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic             mclk_reg;
  logic             sclk_reg;
  logic             lrck_reg;

  // SCLK falls as sc_cnt wraps to 0; a frame begins when both counters are 0
  assign fall_stb  = (sc_cnt_reg == '0);
  assign frame_stb = fall_stb && (bit_cnt_reg == '0);

  // Phase counter within one SCLK period and bit counter within one frame
  always_ff @(posedge clk) begin
    if (srst) begin
      sc_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
    end else if (sc_cnt_reg == SC_LAST) begin
      sc_cnt_reg  <= '0;
      bit_cnt_reg <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
    end else begin
      sc_cnt_reg  <= sc_cnt_reg + 1'b1;
    end
  end

  // Registered pin decode; LRCK follows bit_cnt so it moves only as SCLK falls
  always_ff @(posedge clk) begin
    if (srst) begin
      mclk_reg <= 1'b0;
      sclk_reg <= 1'b0;
      lrck_reg <= 1'b0;
    end else begin
      mclk_reg <= phase_high(int'(sc_cnt_reg) % MCLK_DIV, MCLK_DIV);
      sclk_reg <= phase_high(int'(sc_cnt_reg), SCLK_DIV);
      lrck_reg <= int'(bit_cnt_reg) >= SLOT_W;
    end
  end

  assign mclk = mclk_reg;
  assign sclk = sclk_reg;
  assign lrck = lrck_reg;

endmodule

// File: rtl/cs4344_i2s_tx.sv
// Parallel-to-I2S serializer for the CS4344 DAC: one stereo sample per LRCK
// frame through a single-entry valid/ready holding register.
module cs4344_i2s_tx
#(
  parameter int DATA_W   = cs4344_pkg::DATA_W,
  parameter int SLOT_W   = cs4344_pkg::SLOT_W,
  parameter int SCLK_DIV = cs4344_pkg::SCLK_DIV,
  parameter int MCLK_DIV = cs4344_pkg::MCLK_DIV
) (
  input  logic              Clk,
  input  logic              RST_IN,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCK,
  output logic              SDIN,
  output logic              frame_start,
  output logic              underrun
);
  import cs4344_pkg::*;

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PAD_W   = SLOT_W - DATA_W;

  logic              fall_stb;
  logic              frame_stb;
  logic              xfer;
  logic              hold_full_reg;
  logic              hold_full_next;
  logic [DATA_W-1:0] hold_left_reg;
  logic [DATA_W-1:0] hold_right_reg;
  logic [SLOT_W-1:0] left_slot;
  logic [SLOT_W-1:0] right_slot;
  logic [FRAME_W-1:0] shift_reg;
  logic              s_ready_reg;
  logic              sdin_reg;
  logic              frame_start_reg;
  logic              underrun_reg;

  cs4344_clk_div #(
    .SLOT_W   (SLOT_W),
    .SCLK_DIV (SCLK_DIV),
    .MCLK_DIV (MCLK_DIV)
  ) u_clk_div (
    .clk       (Clk),
    .srst      (RST_IN),
    .mclk      (MCLK),
    .sclk      (SCLK),
    .lrck      (LRCK),
    .fall_stb  (fall_stb),
    .frame_stb (frame_stb)
  );

  // Left-justify each sample in its slot, zero-filling the low bits
  for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_slot
    if (gi >= PAD_W) begin : g_data
      assign left_slot[gi]  = hold_left_reg[gi-PAD_W];
      assign right_slot[gi] = hold_right_reg[gi-PAD_W];
    end else begin : g_pad
      assign left_slot[gi]  = 1'b0;
      assign right_slot[gi] = 1'b0;
    end
  end

  assign xfer = s_valid & s_ready_reg;

  // Holding register occupancy: a boundary drains it, an accept fills it
  always_comb begin
    hold_full_next = hold_full_reg;
    if (frame_stb) hold_full_next = 1'b0;
    if (xfer)      hold_full_next = 1'b1;
  end

  // Handshake, frame load and MSB-first shifting on SCLK falling edges
  always_ff @(posedge Clk) begin
    if (RST_IN) begin
      hold_full_reg   <= 1'b0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      shift_reg       <= '0;
      s_ready_reg     <= 1'b0;
      sdin_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      hold_full_reg   <= hold_full_next;
      s_ready_reg     <= ~hold_full_next;
      frame_start_reg <= frame_stb;
      underrun_reg    <= frame_stb & ~hold_full_reg;
      if (xfer) begin
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
      end
      if (frame_stb) begin
        // Bit 0 of each frame is the I2S one-bit delay slot
        shift_reg <= hold_full_reg ? {left_slot, right_slot} : '0;
        sdin_reg  <= 1'b0;
      end else if (fall_stb) begin
        sdin_reg  <= shift_reg[FRAME_W-1];
        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign s_ready     = s_ready_reg;
  assign SDIN        = sdin_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_cs4344_i2s_tx.sv
// Randomized self-checking bench for cs4344_i2s_tx: a frame-level reference
// model predicts every output pin each cycle for a default instance and for a
// SCLK_DIV=16 / MCLK_DIV=4 instance.
module tb_cs4344_i2s_tx;

  localparam int NB = 64;  // bits per frame (2 x 32-bit slots)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v1 = 1'b0, v2 = 1'b1;
  logic [15:0] l1 = '0, rr1 = '0, l2 = 16'hC001, r2 = 16'h7FFE;
  logic        r1, mclk1, sclk1, lrck1, sdin1, fs1, ur1;
  logic        rdy2, mclk2, sclk2, lrck2, sdin2, fs2, ur2;

  cs4344_i2s_tx u_dut1 (
    .Clk(clk), .RST_IN(rst), .s_valid(v1), .s_ready(r1), .s_left(l1), .s_right(rr1),
    .MCLK(mclk1), .SCLK(sclk1), .LRCK(lrck1), .SDIN(sdin1), .frame_start(fs1), .underrun(ur1)
  );

  cs4344_i2s_tx #(.SCLK_DIV(16), .MCLK_DIV(4)) u_dut2 (
    .Clk(clk), .RST_IN(rst), .s_valid(v2), .s_ready(rdy2), .s_left(l2), .s_right(r2),
    .MCLK(mclk2), .SCLK(sclk2), .LRCK(lrck2), .SDIN(sdin2), .frame_start(fs2), .underrun(ur2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model state, one slot per instance
  int          e[2];       // edges since reset release, -1 while in reset
  int          pos[2];     // Clk position within the frame
  bit          full[2];
  logic [15:0] hl[2], hr[2];
  logic [63:0] fv[2];      // frame vector currently playing
  bit          urf[2];     // current frame started empty
  bit          xf[2];      // transfer happened at the last edge
  int          last_fs[2];
  int          sdiv[2];
  int          mdiv[2];

  // Observation helpers
  int          cyc = 0, ur_seen = 0, obs_x = 0, dec_n = 0, mode = 0;
  bit          rdy_s1 = 1'b0, prev_sclk = 1'b0;
  logic [63:0] dec = '0, last_dec = '0;
  logic [15:0] seq = 16'h1000;

  // Expected {MCLK, SCLK, LRCK, SDIN} at a frame position, from the pin rules
  function automatic logic [3:0] pins(input int p, input int sd, input int md, input logic [63:0] f);
    int   bk, sc;
    logic m, s, lr, d;
    bk = p / sd;
    sc = p % sd;
    m  = (sc % md) >= (md / 2);
    s  = sc >= (sd / 2);
    lr = bk >= 32;
    d  = (bk == 0) ? 1'b0 : f[64 - bk];
    return {m, s, lr, d};
  endfunction

  task automatic tick();
    logic        vin;
    logic [15:0] li, ri;
    logic [6:0]  got, want;
    @(posedge clk);
    if (v1 && rdy_s1) obs_x++;
    for (int d = 0; d < 2; d++) begin
      vin = (d == 0) ? v1 : v2;
      li  = (d == 0) ? l1 : l2;
      ri  = (d == 0) ? rr1 : r2;
      if (rst) begin
        e[d] = -1; pos[d] = 0; full[d] = 1'b0; fv[d] = '0; urf[d] = 1'b0; xf[d] = 1'b0;
      end else begin
        e[d]++;
        pos[d] = e[d] % (NB * sdiv[d]);
        xf[d]  = vin && (e[d] > 0) && !full[d];
        if (pos[d] == 0) begin
          fv[d]   = full[d] ? {hl[d], 16'h0, hr[d], 16'h0} : 64'h0;
          urf[d]  = !full[d];
          full[d] = 1'b0;
        end
        if (xf[d]) begin
          full[d] = 1'b1; hl[d] = li; hr[d] = ri;
        end
      end
    end
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      got = (d == 0) ? {mclk1, sclk1, lrck1, sdin1, fs1, ur1, r1}
                     : {mclk2, sclk2, lrck2, sdin2, fs2, ur2, rdy2};
      want = (e[d] < 0) ? 7'h0
           : {pins(pos[d], sdiv[d], mdiv[d], fv[d]), pos[d] == 0, (pos[d] == 0) && urf[d], !full[d]};
      check((d == 0) ? "pins1" : "pins2", 64'(got), 64'(want));
      if (e[d] < 0) last_fs[d] = -1;
      else if (got[2]) begin
        if (last_fs[d] >= 0) check("fs_period", 64'(cyc - last_fs[d]), 64'(NB * sdiv[d]));
        last_fs[d] = cyc;
      end
    end
    if (e[1] >= 0 && pos[1] == 16 && !urf[1]) check("msb2", 64'(sdin2), 64'(fv[1][63]));
    // Decode DUT1 SDIN at SCLK rising edges into whole frames
    if (e[0] >= 0) begin
      if (pos[0] == 0) begin dec = '0; dec_n = 0; end
      if (!prev_sclk && sclk1) begin dec = {dec[62:0], sdin1}; dec_n++; end
      if (pos[0] == NB * 8 - 1) begin
        check("nbits", 64'(dec_n), 64'd64);
        check("frame1", dec, {1'b0, fv[0][63:1]});
        last_dec = dec;
      end
    end
    prev_sclk = sclk1;
    if (ur1) ur_seen++;
    rdy_s1 = r1;
    // Stimulus for the next edge
    if (xf[1]) begin l2 = 16'($urandom); r2 = 16'($urandom); end
    case (mode)
      0: begin v1 = 1'b0; l1 = 16'($urandom); rr1 = 16'($urandom); end
      2: begin
        v1 = 1'b1;
        if (xf[0]) begin seq++; l1 = seq; rr1 = 16'($urandom); end
      end
      3: begin
        if (xf[0] || !v1) begin
          v1 = ($urandom_range(0, 299) == 0);
          l1 = 16'($urandom); rr1 = 16'($urandom);
        end
      end
      default: ;
    endcase
  endtask

  // Advance at least one cycle, then until DUT1's frame position equals p
  task automatic run_to(input int p, input string tag);
    int k;
    k = 0;
    tick();
    while (!(e[0] >= 0 && pos[0] == p) && k < 1100) begin tick(); k++; end
    check(tag, 64'(k < 1100), 64'd1);
  endtask

  initial begin
    int          k, u0, x0;
    logic [63:0] exp_b;
    sdiv = '{8, 16};
    mdiv = '{2, 4};
    e = '{-1, -1}; pos = '{0, 0}; full = '{0, 0}; fv = '{64'h0, 64'h0};
    urf = '{0, 0}; xf = '{0, 0}; last_fs = '{-1, -1};
    hl = '{16'h0, 16'h0}; hr = '{16'h0, 16'h0};

    // Reset, then idle: silence with an underrun at every boundary
    repeat (4) tick();
    rst = 1'b0;
    repeat (2 * 512 + 8) tick();
    check("ur_idle", 64'(ur_seen), 64'd3);

    // One fixed sample
    mode = 1; l1 = 16'hA5C3; rr1 = 16'h8001; v1 = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!xf[0] && k < 1000);
    check("accept_b", 64'(k < 1000), 64'd1);
    v1 = 1'b0; mode = 0;
    run_to(0, "wait_b0");
    run_to(511, "wait_b1");
    exp_b = {1'b0, 16'hA5C3, 16'h0000, 16'h8001, 15'h0000};
    check("a5c3", last_dec, exp_b);

    // Continuous stream of incrementing samples
    l1 = seq; rr1 = 16'($urandom); v1 = 1'b1; mode = 2;
    repeat (1024) tick();
    u0 = ur_seen; x0 = obs_x;
    repeat (5 * 512) tick();
    check("xfer_per_frame", 64'(obs_x - x0), 64'd5);
    check("ur_stream", 64'(ur_seen - u0), 64'd0);

    // One frame's sample missing
    run_to(100, "wait_d");
    v1 = 1'b0; mode = 0; u0 = ur_seen;
    repeat (1024) tick();
    l1 = seq; rr1 = 16'($urandom); v1 = 1'b1; mode = 2;
    repeat (3 * 512) tick();
    check("ur_skip", 64'(ur_seen - u0), 64'd1);

    // Reset at bit 20 of a playing frame with another sample held
    run_to(160, "wait_e");
    check("held_e", 64'({full[0], urf[0]}), 64'b10);
    rst = 1'b1; mode = 0;
    tick();
    check("rst_all", 64'({mclk1, sclk1, lrck1, sdin1, fs1, ur1, r1}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rel_fs", 64'(fs1), 64'd1);
    check("rel_ur", 64'(ur1), 64'd1);
    repeat (600) tick();

    // Sparse random traffic
    mode = 3;
    repeat (6 * 512) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
